// File: rtl/lifo_pkg.sv
// Shared constants for the LIFO stack: default geometry and operation encoding.
package lifo_pkg;

    localparam int LIFO_WIDTH = 8;
    localparam int LIFO_DEPTH = 16;

    // Value of read_write_bar selecting each operation.
    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

endpackage : lifo_pkg

// File: rtl/lifo_mem.sv
// DEPTH x WIDTH register array: synchronous write port, asynchronous read port.
module lifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Store the pushed word at the current write slot.
    // NOTE: the array has no reset; an empty count already makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule : lifo_mem

// File: rtl/lifo_stack.sv
// LIFO stack: one push or pop per clock, with full/empty flags and a
// one-operation error flag for push-when-full or pop-when-empty.
module lifo_stack
    import lifo_pkg::*;
#(
    parameter int WIDTH = LIFO_WIDTH,
    parameter int DEPTH = LIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             read_write_bar,
    output logic [WIDTH-1:0] read_data,
    input  logic [WIDTH-1:0] write_data,
    output logic             full,
    output logic             empty,
    output logic             error
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] read_data_q, read_data_d;
    logic             error_q, error_d;

    logic             mem_we;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;

    // Next free slot is count; top of stack is count-1 (unused while empty).
    assign wr_addr = count_q[AW-1:0];
    assign rd_addr = AW'(count_q - 1'b1);

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);

    lifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .wr_addr (wr_addr),
        .wr_data (write_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Decide this cycle's operation: legal push/pop moves count, illegal one flags error.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        count_d     = count_q;
        read_data_d = read_data_q;
        error_d     = 1'b0;
        mem_we      = 1'b0;
        if (read_write_bar == OP_PUSH) begin
            if (full) begin
                error_d = 1'b1;
            end else begin
                mem_we  = 1'b1;
                count_d = count_q + 1'b1;
            end
        end else begin
            if (empty) begin
                error_d = 1'b1;
            end else begin
                read_data_d = rd_data;
                count_d     = count_q - 1'b1;
            end
        end
    end

    // State registers; reset empties the stack and clears the output word and error.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments so all registers update together at the edge.
        if (!rst) begin
            count_q     <= '0;
            read_data_q <= '0;
            error_q     <= 1'b0;
        end else begin
            count_q     <= count_d;
            read_data_q <= read_data_d;
            error_q     <= error_d;
        end
    end

    assign read_data = read_data_q;
    assign error     = error_q;

endmodule : lifo_stack

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack: directed scenarios plus random traffic,
// compared each cycle against a queue-based model of a bounded stack.
module tb_lifo_stack;
    import lifo_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             read_write_bar;
    logic [WIDTH-1:0] read_data;
    logic [WIDTH-1:0] write_data;
    logic             full;
    logic             empty;
    logic             error;

    int errors = 0;
    int checks = 0;

    // Reference model: the stack contents, plus the expected registered outputs.
    logic [WIDTH-1:0] model_q [$];
    logic [WIDTH-1:0] exp_rd;
    logic             exp_err;

    lifo_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .read_write_bar (read_write_bar),
        .read_data      (read_data),
        .write_data     (write_data),
        .full           (full),
        .empty          (empty),
        .error          (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".read_data"}, 32'(read_data), 32'(exp_rd));
        check({tag, ".error"},     32'(error),     32'(exp_err));
        check({tag, ".full"},      32'(full),  32'(model_q.size() == DEPTH));
        check({tag, ".empty"},     32'(empty), 32'(model_q.size() == 0));
    endtask

    // One clock of traffic: drive at negedge, update model at posedge, sample 1 time unit later.
    task automatic do_op(input logic op, input logic [WIDTH-1:0] data, input string tag);
        @(negedge clk);
        read_write_bar = op;
        write_data     = data;
        @(posedge clk);
        if (op == OP_PUSH) begin
            if (model_q.size() < DEPTH) begin
                model_q.push_back(data);
                exp_err = 1'b0;
            end else begin
                exp_err = 1'b1;
            end
        end else begin
            if (model_q.size() > 0) begin
                exp_rd  = model_q.pop_back();
                exp_err = 1'b0;
            end else begin
                exp_err = 1'b1;
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_rd  = '0;
        exp_err = 1'b0;
    endtask

    initial begin
        rst            = 1'b0;
        read_write_bar = OP_POP;
        write_data     = '0;
        model_reset();

        // Reset state, then idle pops on an empty stack.
        #2;
        check_all("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) do_op(OP_POP, 8'h00, "idle_pop");

        // Push 0..14, then pop 25 times: 14..0 then 10 erroring pops holding 0.
        for (int i = 0; i < 15; i++) do_op(OP_PUSH, WIDTH'(i), "order_push");
        for (int i = 0; i < 25; i++) do_op(OP_POP, 8'h00, "order_pop");

        // Fill to DEPTH, overflow once, then pop the top.
        for (int i = 0; i < 16; i++) do_op(OP_PUSH, WIDTH'(8'hA0 + i), "fill_push");
        do_op(OP_PUSH, 8'hFF, "overflow_push");
        do_op(OP_POP, 8'h00, "after_overflow_pop");
        for (int i = 0; i < 15; i++) do_op(OP_POP, 8'h00, "drain_pop");

        // Alternating push/pop on an empty stack.
        do_op(OP_PUSH, 8'h55, "alt_push55");
        do_op(OP_POP,  8'h00, "alt_pop55");
        do_op(OP_PUSH, 8'h66, "alt_push66");
        do_op(OP_POP,  8'h00, "alt_pop66");

        // Random traffic: push-biased, pop-biased, then unbiased.
        for (int i = 0; i < 80; i++)
            do_op(($urandom_range(0, 3) == 0) ? OP_POP : OP_PUSH, WIDTH'($urandom), "rand_pushy");
        for (int i = 0; i < 80; i++)
            do_op(($urandom_range(0, 3) == 0) ? OP_PUSH : OP_POP, WIDTH'($urandom), "rand_poppy");
        for (int i = 0; i < 200; i++)
            do_op(1'($urandom_range(0, 1)), WIDTH'($urandom), "rand_mix");

        // Reset mid-stream: push 5 words, pop one so read_data is non-zero, reset between edges.
        for (int i = 0; i < 5; i++) do_op(OP_PUSH, WIDTH'(8'h30 + i), "pre_reset_push");
        do_op(OP_POP, 8'h00, "pre_reset_pop");
        @(posedge clk);
        model_q.push_back(8'h00);   // model state here is discarded by the reset below
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) do_op(OP_POP, 8'h00, "post_reset_pop");
        do_op(OP_PUSH, 8'h77, "post_reset_push");
        do_op(OP_POP,  8'h00, "post_reset_pop77");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_lifo_stack

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
- Synchronous last-in-first-out stack of WIDTH-bit words, DEPTH entries deep.
- Used as a local scratch/return-value buffer between a producer and a consumer in the same clock domain.
- A single direction control selects push or pop every clock cycle.
- Status outputs report full, empty and illegal-operation (error).

Parameters:
- WIDTH, 8: data word width in bits.
- DEPTH, 16: number of storage entries. Must be a power of two and at least 2.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- read_write_bar  input  1  operation select: 1 = pop (read), 0 = push (write).
- read_data  output  WIDTH  registered data of the most recent successful pop.
- write_data  input  WIDTH  data pushed on a write cycle.
- full  output  1  stack holds DEPTH entries.
- empty  output  1  stack holds 0 entries.
- error  output  1  registered flag; previous operation was illegal.

Behaviour:
- Reset (rst low, asynchronous, dominates everything):
  - count=0, read_data=0, error=0.
  - Therefore empty=1 and full=0.
  - Storage array contents are not reset.
- State: count, width clog2(DEPTH)+1, range 0..DEPTH. The top of stack is entry count-1.
- Every rising edge with rst high performs exactly one operation. There is no enable; the stack is never idle.
- Push (read_write_bar=0):
  - If count<DEPTH: mem[count] <= write_data, count <= count+1, error <= 0.
  - If full: storage and count are unchanged, error <= 1.
  - read_data is unchanged on every push.
- Pop (read_write_bar=1):
  - If count>0: read_data <= mem[count-1], count <= count-1, error <= 0.
  - If empty: count and read_data are unchanged (read_data holds its last value), error <= 1.
- Latency: a popped word appears on read_data one clock after the popping edge.
- Pushed data is poppable on the very next cycle; push-then-pop returns the same word.
- full = (count==DEPTH) and empty = (count==0). Both are decoded combinationally from the registered count, so they update in the same cycle count changes.
- error is sticky only for one operation: it is re-evaluated on every edge and clears on the first legal operation.
- Reset mid-operation: the stack empties immediately, and prior contents are unrecoverable via pop.
- No simultaneous push/pop is possible by construction. Pointer wrap-around never occurs because count saturates at 0 and DEPTH.

Decomposition:
- Shared package lifo_pkg holds:
  - default constants LIFO_WIDTH=8 and LIFO_DEPTH=16;
  - the operation encoding constants OP_PUSH=1'b0 and OP_POP=1'b1.
- One natural sub-module, lifo_mem: a DEPTH x WIDTH register array with a synchronous write port and an asynchronous read port addressed by count-1.
- Count, flag and error logic stay in lifo_stack.

Test Plan:
- Reset then idle pops: assert rst low for 1 cycle, release, hold read_write_bar=1 for 3 cycles -> empty=1, full=0, read_data=0, error=1 from the first pop edge onward.
- Push/pop ordering: push 0..14 on 15 consecutive cycles, then pop 25 cycles.
  - Pops return read_data 14,13,...,0 on successive cycles and error stays 0.
  - After the 15th pop, empty=1.
  - The remaining 10 pops give error=1 with read_data held at 0.
- Full boundary: push 16 words 0xA0..0xAF -> full=1 after the 16th edge. A 17th push of 0xFF sets error=1 and leaves count at 16. The next pop returns 0xAF and clears error.
- Alternating: push 0x55, pop, push 0x66, pop -> read_data 0x55 then 0x66. empty returns to 1 after each pop and error stays 0.
- Reset mid-stream: push 5 words, assert rst asynchronously between edges -> empty=1 and read_data=0 immediately. Subsequent pops flag error=1.
